// File: rtl/ram_wb_arbiter.sv
// Two-master / one-slave Wishbone B3 arbiter in front of the on-chip RAM.
// Round-robin grant held for a whole cycle, plus a per-grant stall watchdog.
module ram_wb_arbiter #(
    parameter int dw             = 32,
    parameter int aw             = 32,
    parameter int timeout_cycles = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,

    input  logic [aw-1:0] m0_adr_i,
    input  logic [dw-1:0] m0_dat_i,
    input  logic [3:0]    m0_sel_i,
    input  logic          m0_we_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic [2:0]    m0_cti_i,
    input  logic [1:0]    m0_bte_i,
    output logic [dw-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    output logic          m0_rty_o,

    input  logic [aw-1:0] m1_adr_i,
    input  logic [dw-1:0] m1_dat_i,
    input  logic [3:0]    m1_sel_i,
    input  logic          m1_we_i,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic [2:0]    m1_cti_i,
    input  logic [1:0]    m1_bte_i,
    output logic [dw-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          m1_rty_o,

    output logic [aw-1:0] s_adr_o,
    output logic [dw-1:0] s_dat_o,
    output logic [3:0]    s_sel_o,
    output logic          s_we_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic [2:0]    s_cti_o,
    output logic [1:0]    s_bte_o,
    input  logic [dw-1:0] s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,
    input  logic          s_rty_i
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    localparam logic [15:0] WD_LAST = 16'(timeout_cycles - 1);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [15:0] wdog_q, wdog_d;

    logic g_cyc, g_stb, o_cyc, stalled, wd_fire;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        wdog_d   = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_cti_o  = '0;
        s_bte_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;

        g_cyc = (state_q == GNT1) ? m1_cyc_i : m0_cyc_i;
        g_stb = (state_q == GNT1) ? m1_stb_i : m0_stb_i;
        o_cyc = (state_q == GNT1) ? m0_cyc_i : m1_cyc_i;

        // Any slave response in the same cycle pre-empts the watchdog.
        stalled = (state_q != IDLE) && g_stb && !(s_ack_i || s_err_i || s_rty_i);
        wd_fire = stalled && (wdog_q == WD_LAST);

        case (state_q)
            GNT0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & ~wd_fire;
                s_cti_o  = m0_cti_i;
                s_bte_o  = m0_bte_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | wd_fire;
                m0_rty_o = s_rty_i;
            end
            GNT1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & ~wd_fire;
                s_cti_o  = m1_cti_i;
                s_bte_o  = m1_bte_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | wd_fire;
                m1_rty_o = s_rty_i;
            end
            default: begin
                if (m0_cyc_i && m1_cyc_i)
                    state_d = last_q ? GNT0 : GNT1;
                else if (m0_cyc_i)
                    state_d = GNT0;
                else if (m1_cyc_i)
                    state_d = GNT1;
            end
        endcase

        // Only cyc falling ends a grant; hand over directly if the other side waits.
        if (state_q != IDLE) begin
            if (!g_cyc) begin
                last_d = (state_q == GNT1);
                if (o_cyc)
                    state_d = (state_q == GNT1) ? GNT0 : GNT1;
                else
                    state_d = IDLE;
            end else if (stalled && !wd_fire) begin
                wdog_d = wdog_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ram_wb_arbiter.sv
// Self-checking bench for ram_wb_arbiter: directed scenarios plus a randomized
// run scored against a grant/stall-count reference model.
module tb_ram_wb_arbiter;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  cyc, stb, we;
    logic [31:0] adr  [2];
    logic [31:0] wdat [2];
    logic [3:0]  sel  [2];
    logic [2:0]  cti  [2];
    logic [1:0]  bte  [2];
    logic [31:0] mdat [2];
    logic [1:0]  ack_o, err_o, rty_o;

    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]  s_cti_o;
    logic [1:0]  s_bte_o;
    logic        s_ack, s_err, s_rty;

    int cmp  = 0;
    int mism = 0;

    always #5 clk = ~clk;

    ram_wb_arbiter #(.dw(32), .aw(32), .timeout_cycles(T)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_sel_i(sel[0]), .m0_we_i(we[0]),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_cti_i(cti[0]), .m0_bte_i(bte[0]),
        .m0_dat_o(mdat[0]), .m0_ack_o(ack_o[0]), .m0_err_o(err_o[0]), .m0_rty_o(rty_o[0]),
        .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_sel_i(sel[1]), .m1_we_i(we[1]),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_cti_i(cti[1]), .m1_bte_i(bte[1]),
        .m1_dat_o(mdat[1]), .m1_ack_o(ack_o[1]), .m1_err_o(err_o[1]), .m1_rty_o(rty_o[1]),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty)
    );

    // Reference model: who owns the slave, who was served last, how long stalled.
    int m_owner = -1;
    int m_last  = 1;
    int m_stall = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1;
            m_last  = 1;
            m_stall = 0;
        end else if (m_owner < 0) begin
            m_stall = 0;
            if (cyc[0] && cyc[1]) m_owner = 1 - m_last;
            else if (cyc[0])      m_owner = 0;
            else if (cyc[1])      m_owner = 1;
        end else if (!cyc[m_owner]) begin
            m_last  = m_owner;
            m_owner = cyc[1 - m_owner] ? 1 - m_owner : -1;
            m_stall = 0;
        end else if (stb[m_owner] && !(s_ack || s_err || s_rty)) begin
            m_stall = (m_stall + 1) % T;
        end else begin
            m_stall = 0;
        end
    end

    task automatic clear_inputs();
        cyc = '0; stb = '0; we = '0;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat_i = 32'h0;
        for (int m = 0; m < 2; m++) begin
            adr[m] = 32'h0; wdat[m] = 32'h0; sel[m] = 4'h0; cti[m] = 3'h0; bte[m] = 2'h0;
        end
    endtask

    // Leaves the caller at a negedge with the arbiter freshly reset to IDLE.
    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        cyc = 2'b11; stb = 2'b11; adr[0] = 32'hA000; adr[1] = 32'hB000; s_ack = 1'b1;
        #1;
        cmp++; if (s_cyc_o !== 1'b0) begin mism++; $display("FAIL reset_cyc: got %b want 0", s_cyc_o); end
        cmp++; if (s_stb_o !== 1'b0) begin mism++; $display("FAIL reset_stb: got %b want 0", s_stb_o); end
        cmp++; if ({ack_o, err_o, rty_o} !== 6'b0) begin mism++; $display("FAIL reset_resp: got %b want 0", {ack_o, err_o, rty_o}); end
        cmp++; if (s_adr_o !== 32'h0) begin mism++; $display("FAIL reset_adr: got %h want 0", s_adr_o); end
        @(negedge clk); s_ack = 1'b0; #1;
        cmp++; if (s_adr_o !== 32'hA000) begin mism++; $display("FAIL reset_first_winner: got %h want a000", s_adr_o); end
    endtask

    task automatic test_single_read();
        do_reset();
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h100; #1;
        cmp++; if (s_cyc_o !== 1'b0) begin mism++; $display("FAIL read_latency: got %b want 0", s_cyc_o); end
        @(negedge clk); #1;
        cmp++; if (s_cyc_o !== 1'b1) begin mism++; $display("FAIL read_cyc: got %b want 1", s_cyc_o); end
        cmp++; if (s_adr_o !== 32'h100) begin mism++; $display("FAIL read_adr: got %h want 100", s_adr_o); end
        s_ack = 1'b1; s_dat_i = 32'hCAFE_F00D; #1;
        cmp++; if (ack_o !== 2'b01) begin mism++; $display("FAIL read_ack: got %b want 01", ack_o); end
        cmp++; if (mdat[0] !== 32'hCAFE_F00D || mdat[1] !== 32'hCAFE_F00D) begin mism++; $display("FAIL read_dat: got %h/%h want cafef00d", mdat[0], mdat[1]); end
        @(negedge clk); s_ack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
        @(negedge clk); cyc[0] = 1'b1; #1;
        cmp++; if (s_cyc_o !== 1'b0) begin mism++; $display("FAIL read_release_idle: got %b want 0", s_cyc_o); end
    endtask

    task automatic test_rotation();
        do_reset();
        adr[0] = 32'hA0; adr[1] = 32'hB0; cyc = 2'b11; stb = 2'b11;
        @(negedge clk); #1;
        cmp++; if (s_adr_o !== 32'hA0) begin mism++; $display("FAIL rot_first: got %h want a0", s_adr_o); end
        s_ack = 1'b1; cyc[0] = 1'b0; stb[0] = 1'b0; #1;
        cmp++; if (ack_o !== 2'b01) begin mism++; $display("FAIL rot_ack_on_drop: got %b want 01", ack_o); end
        @(negedge clk); s_ack = 1'b0; #1;
        cmp++; if (s_adr_o !== 32'hB0 || s_cyc_o !== 1'b1) begin mism++; $display("FAIL rot_handover: got %h/%b want b0/1", s_adr_o, s_cyc_o); end
        @(negedge clk); cyc[1] = 1'b0; stb[1] = 1'b0;
        @(negedge clk); cyc = 2'b11; stb = 2'b11;
        @(negedge clk); #1;
        cmp++; if (s_adr_o !== 32'hA0) begin mism++; $display("FAIL rot_next_m0: got %h want a0", s_adr_o); end
    endtask

    task automatic test_burst();
        do_reset();
        cyc[1] = 1'b1; stb[1] = 1'b1; cti[1] = 3'b010; bte[1] = 2'b01; adr[1] = 32'h20;
        adr[0] = 32'h900;
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            adr[1] = 32'h20 + 32'(4 * i);
            cti[1] = (i == 3) ? 3'b111 : 3'b010;
            s_ack = 1'b1; #1;
            cmp++; if (s_adr_o !== adr[1] || s_cti_o !== cti[1] || s_bte_o !== 2'b01) begin mism++; $display("FAIL burst_beat%0d: got %h/%b/%b want %h/%b/01", i, s_adr_o, s_cti_o, s_bte_o, adr[1], cti[1]); end
            cmp++; if (ack_o !== 2'b10) begin mism++; $display("FAIL burst_ack%0d: got %b want 10", i, ack_o); end
        end
        @(negedge clk); s_ack = 1'b0; #1;
        cmp++; if (s_adr_o !== 32'h2C) begin mism++; $display("FAIL burst_hold_after_111: got %h want 2c", s_adr_o); end
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(negedge clk); #1;
        cmp++; if (s_adr_o !== 32'h900 || s_cyc_o !== 1'b1) begin mism++; $display("FAIL burst_m0_after: got %h/%b want 900/1", s_adr_o, s_cyc_o); end
    endtask

    task automatic test_watchdog();
        int fires;
        fires = 0;
        do_reset();
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h44;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk); #1;
            if (err_o[0]) fires++;
            cmp++; if (err_o[0] !== (k % T == 0) || s_stb_o !== (k % T != 0)) begin mism++; $display("FAIL wdog_cycle%0d: got err=%b stb=%b want err=%b stb=%b", k, err_o[0], s_stb_o, k % T == 0, k % T != 0); end
        end
        cmp++; if (fires !== 2) begin mism++; $display("FAIL wdog_count: got %0d want 2", fires); end
        cmp++; if (s_cyc_o !== 1'b1 || err_o[1] !== 1'b0) begin mism++; $display("FAIL wdog_grant_kept: got cyc=%b err1=%b want 1/0", s_cyc_o, err_o[1]); end
    endtask

    task automatic test_err_route();
        do_reset();
        cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 32'hFFFF_0000;
        for (int k = 1; k < T; k++) @(negedge clk);
        @(negedge clk); s_err = 1'b1; #1;
        cmp++; if (err_o !== 2'b10) begin mism++; $display("FAIL err_route: got %b want 10", err_o); end
        cmp++; if (s_stb_o !== 1'b1) begin mism++; $display("FAIL err_no_wdog_mask: got %b want 1", s_stb_o); end
        @(negedge clk); s_err = 1'b0; #1;
        cmp++; if (err_o !== 2'b00) begin mism++; $display("FAIL err_wdog_cleared: got %b want 00", err_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc[1] = 1'b1; stb[1] = 1'b1; cti[1] = 3'b010; adr[1] = 32'h60; adr[0] = 32'h70;
        @(negedge clk); #1;
        cmp++; if (s_adr_o !== 32'h60) begin mism++; $display("FAIL rstmid_gnt1: got %h want 60", s_adr_o); end
        cyc[0] = 1'b1; stb[0] = 1'b1; s_ack = 1'b1; rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        cmp++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin mism++; $display("FAIL rstmid_bus: got cyc=%b stb=%b want 0/0", s_cyc_o, s_stb_o); end
        cmp++; if (ack_o !== 2'b00) begin mism++; $display("FAIL rstmid_ack: got %b want 00", ack_o); end
        @(negedge clk); s_ack = 1'b0; #1;
        cmp++; if (s_adr_o !== 32'h70) begin mism++; $display("FAIL rstmid_m0_wins: got %h want 70", s_adr_o); end
    endtask

    task automatic test_random();
        logic [75:0] exp_bus, act_bus;
        logic [5:0]  exp_resp, act_resp;
        logic        fire, quiet;
        int          n, r;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            quiet = (i % 100) >= 70;
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(0, 9) == 0) cyc[m] = ~cyc[m];
                stb[m]  = cyc[m] & (quiet || $urandom_range(0, 3) != 0);
                adr[m]  = $urandom; wdat[m] = $urandom;
                sel[m]  = 4'($urandom); we[m] = 1'($urandom);
                cti[m]  = 3'($urandom); bte[m] = 2'($urandom);
            end
            r = quiet ? 9 : $urandom_range(0, 9);
            s_ack = (r < 3); s_err = (r == 3); s_rty = (r == 4);
            s_dat_i = $urandom;
            #1;
            n = m_owner;
            fire = (n >= 0) && stb[n] && !(s_ack || s_err || s_rty) && (m_stall == T - 1);
            exp_bus  = '0;
            exp_resp = '0;
            if (n >= 0) begin
                exp_bus = {adr[n], wdat[n], sel[n], we[n], cyc[n], stb[n] & ~fire, cti[n], bte[n]};
                if (n == 0) exp_resp[2:0] = {s_ack, s_err | fire, s_rty};
                else        exp_resp[5:3] = {s_ack, s_err | fire, s_rty};
            end
            act_bus  = {s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o};
            act_resp = {ack_o[1], err_o[1], rty_o[1], ack_o[0], err_o[0], rty_o[0]};
            cmp++; if (act_bus !== exp_bus) begin mism++; $display("FAIL rand_bus@%0d: got %h want %h", i, act_bus, exp_bus); end
            cmp++; if (act_resp !== exp_resp) begin mism++; $display("FAIL rand_resp@%0d: got %b want %b", i, act_resp, exp_resp); end
            cmp++; if (mdat[0] !== s_dat_i || mdat[1] !== s_dat_i) begin mism++; $display("FAIL rand_dat@%0d: got %h/%h want %h", i, mdat[0], mdat[1], s_dat_i); end
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_rotation();
        test_burst();
        test_watchdog();
        test_err_route();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end

endmodule

// File: doc/ram_wb_arbiter.md
Name: ram_wb_arbiter

Overview:
- Two-master, one-slave Wishbone B3 arbiter that shares the on-chip RAM slave between the instruction bus (m0) and the data bus (m1).
- Round-robin grant, held for a whole cycle so registered-feedback bursts (cti 001/010 ... 111) are never split.
- Per-grant watchdog: a stalled slave returns an error to its master instead of hanging the bus.
- Sits between the CPU bus masters and the RAM slave port.

Parameters:
- dw, 32, data width.
- aw, 32, address width.
- timeout_cycles, 255, stalled-strobe cycles before a watchdog error; range 2..65535.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- mN_adr_i (N=0,1)  in  aw  master address.
- mN_dat_i  in  dw  master write data.
- mN_sel_i  in  4  master byte selects.
- mN_we_i  in  1  master write enable.
- mN_cyc_i  in  1  master cycle.
- mN_stb_i  in  1  master strobe.
- mN_cti_i  in  3  master cycle type.
- mN_bte_i  in  2  master burst type.
- mN_dat_o  out  dw  read data; s_dat_i broadcast to both masters.
- mN_ack_o  out  1  ack to master N.
- mN_err_o  out  1  error to master N.
- mN_rty_o  out  1  retry to master N.
- s_adr_o  out  aw  slave address.
- s_dat_o  out  dw  slave write data.
- s_sel_o  out  4  slave byte selects.
- s_we_o  out  1  slave write enable.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_cti_o  out  3  slave cycle type.
- s_bte_o  out  2  slave burst type.
- s_dat_i  in  dw  slave read data.
- s_ack_i  in  1  slave ack.
- s_err_i  in  1  slave error.
- s_rty_i  in  1  slave retry.

Behaviour:
- FSM states: IDLE, GNT0, GNT1. The state is a register.
  - Reset: state=IDLE, last=1 (m0 wins first contention), wdog=0.
- IDLE:
  - Slave port outputs all zero.
  - All master ack/err/rty = 0.
  - Arbitration latency is one cycle: requests sampled in IDLE take effect the next cycle.
  - m0_cyc_i only -> GNT0; m1_cyc_i only -> GNT1.
  - Both: last=1 -> GNT0, last=0 -> GNT1. Otherwise stay in IDLE.
- GNTn, combinational muxing:
  - s_adr/dat/sel/we/cti/bte_o = mN_*_i.
  - s_cyc_o = mN_cyc_i.
  - s_stb_o = mN_stb_i & !wd_fire.
  - mN_ack_o = s_ack_i; mN_rty_o = s_rty_i; mN_err_o = s_err_i | wd_fire.
  - The non-granted master's ack/err/rty are 0.
- Grant release happens only when mN_cyc_i = 0 in GNTn.
  - Register last = n.
  - If the other master's cyc_i = 1, move directly to its GNT state (no IDLE bubble). Otherwise go to IDLE.
  - Neither stb low mid-burst nor cti = 111 releases the grant.
- Watchdog:
  - wdog counts in GNTn while mN_stb_i = 1 and s_ack_i|s_err_i|s_rty_i = 0.
  - It clears on any slave response, on stb low, on a state change and on reset.
  - wd_fire = (wdog == timeout_cycles-1) & stalled condition. This raises mN_err_o for exactly that cycle, masks s_stb_o, and clears wdog.
  - The grant is kept; the master must drop cyc.
- Simultaneous events:
  - Slave response and wd_fire in the same cycle: the response wins and wd_fire is suppressed.
  - A master dropping cyc in the same cycle as the slave ack: the ack is still passed to that master, and the grant releases on that edge.
- Reset mid-operation: the next cycle is IDLE with all outputs 0, regardless of in-flight bursts.
- mN_dat_o = s_dat_i at all times.
- No registered datapath: zero added latency on address, data and ack.

Test Plan:
- m0 single read with adr=0x100 and cyc/stb held → s_cyc_o=1 from the second cycle, s_adr_o=0x100; m0_ack_o mirrors s_ack_i while m1_ack_o stays 0; after m0 drops cyc, state=IDLE.
- Both cyc rise together after reset → m0 granted first. When m0 drops cyc with m1 still requesting, s_adr_o switches to m1_adr_i on the next cycle with no IDLE cycle. The next contention after m1 finishes goes to m0 (last=1).
- m1 runs a 4-beat incrementing burst (cti=010, bte=01, adr 0x20,0x24,0x28,0x2C, last beat cti=111) while m0 requests → m1 keeps the grant for all 4 acks. m0 is granted only after m1_cyc_i falls, and receives no acks during the burst.
- Slave never acks, timeout_cycles=8, m0 stb held → m0_err_o=1 exactly once on the 8th stalled cycle with s_stb_o=0 that cycle. The counter restarts and errors again 8 cycles later if stb is still held.
- wb_rst_i pulsed mid-burst in GNT1 → next cycle: s_cyc_o=0, s_stb_o=0, all master acks 0. A subsequent simultaneous request grants m0.
- s_err_i asserted by the slave (out-of-range address) → routed to the granted master's err_o only. The watchdog does not fire that cycle.
